conv1d_tap_scheduler: RTL and testbench

CONV1D_TAP_SCHEDULER -- requirements
Module: conv1d_tap_scheduler

---
 rtl/conv1d_pkg.sv | 21 ++
 rtl/conv1d_loop_cnt.sv | 38 +++
 rtl/conv1d_tap_scheduler.sv | 155 +++++++++++++++
 tb/tb_conv1d_tap_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the conv1d tap scheduler: FSM state encoding
// and the output-length / index-width constant functions.
package conv1d_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic int out_len(input int in_len, input int k, input int stride,
                                 input int dil, input int pad);
    return (in_len + 2 * pad - dil * (k - 1) - 1) / stride + 1;
  endfunction

  // Index width that never collapses to zero bits for a modulus of 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv1d_loop_cnt.sv
// One level of the nested loop: modulo-MOD counter with synchronous clear.
// nxt exposes the next-cycle value so the parent can register tap fields from it.
import conv1d_pkg::*;

module conv1d_loop_cnt #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  // wrap flags the terminal value; the parent gates it with its own inc.
  assign wrap = (count == W'(MOD - 1));

  always_comb begin
    nxt = count;
    if (clr) begin
      nxt = '0;
    end else if (inc) begin
      nxt = wrap ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/conv1d_tap_scheduler.sv
// Walks co/pos/ci/k and issues one registered tap descriptor per handshake.
// Optional perf counters (stall_cnt, tap_cnt) are built when CONV1D_SCHED_PERF_EN is defined.
//
// Handshake: a tap transfers on a rising edge where tap_valid && tap_ready; while
// tap_valid is high and tap_ready low every tap field holds. abort drops the pending tap.
import conv1d_pkg::*;

module conv1d_tap_scheduler #(
  parameter int IN_LEN = 8,
  parameter int CIN    = 2,
  parameter int COUT   = 2,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int DIL    = 1,
  parameter int PAD    = 1,
  localparam int OUT_LEN = out_len(IN_LEN, K, STRIDE, DIL, PAD),
  localparam int XA_W    = $clog2(CIN * IN_LEN),
  localparam int WA_W    = $clog2(COUT * CIN * K),
  localparam int CO_W    = idx_w(COUT),
  localparam int OP_W    = idx_w(OUT_LEN),
  localparam int CI_W    = idx_w(CIN),
  localparam int K_W     = idx_w(K)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            tap_valid,
  input  logic            tap_ready,
  output logic [XA_W-1:0] x_addr,
  output logic [WA_W-1:0] w_addr,
  output logic            tap_pad,
  output logic            tap_first,
  output logic            tap_last,
  output logic [CO_W-1:0] out_ch,
  output logic [OP_W-1:0] out_pos,
  output logic            busy,
  output logic            done
`ifdef CONV1D_SCHED_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     tap_cnt
`endif
);

  state_t state;

  logic            hs, clr, final_tap, load, job_start;
  logic [CO_W-1:0] co_q, co_n;
  logic [OP_W-1:0] pos_q, pos_n;
  logic [CI_W-1:0] ci_q, ci_n;
  logic [K_W-1:0]  k_q, k_n;
  logic            co_wrap, pos_wrap, ci_wrap, k_wrap;

  int              ipos, xa_i;
  logic [XA_W-1:0] x_addr_d;
  logic [WA_W-1:0] w_addr_d;
  logic            pad_d, first_d, last_d;

  assign hs        = (state == S_RUN) && tap_valid && tap_ready;
  assign clr       = (state != S_RUN) || abort;
  assign final_tap = co_wrap && pos_wrap && ci_wrap && k_wrap;
  assign job_start = (state == S_IDLE) && start && !abort;
  assign load      = job_start || (hs && !final_tap && !abort);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  // Counters track the tap currently presented; they move only on a handshake.
  conv1d_loop_cnt #(.MOD(K), .W(K_W)) u_k (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(hs),
    .count(k_q), .nxt(k_n), .wrap(k_wrap)
  );
  conv1d_loop_cnt #(.MOD(CIN), .W(CI_W)) u_ci (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(hs && k_wrap),
    .count(ci_q), .nxt(ci_n), .wrap(ci_wrap)
  );
  conv1d_loop_cnt #(.MOD(OUT_LEN), .W(OP_W)) u_pos (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(hs && k_wrap && ci_wrap),
    .count(pos_q), .nxt(pos_n), .wrap(pos_wrap)
  );
  conv1d_loop_cnt #(.MOD(COUT), .W(CO_W)) u_co (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(hs && k_wrap && ci_wrap && pos_wrap),
    .count(co_q), .nxt(co_n), .wrap(co_wrap)
  );

  // Descriptor of the tap the counters will point at after this edge.
  always_comb begin
    ipos     = int'(pos_n) * STRIDE - PAD + int'(k_n) * DIL;
    pad_d    = (ipos < 0) || (ipos >= IN_LEN);
    xa_i     = pad_d ? 0 : int'(ci_n) * IN_LEN + ipos;
    x_addr_d = XA_W'(xa_i);
    w_addr_d = WA_W'((int'(co_n) * CIN + int'(ci_n)) * K + int'(k_n));
    first_d  = (ci_n == '0) && (k_n == '0);
    last_d   = (ci_n == CI_W'(CIN - 1)) && (k_n == K_W'(K - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tap_valid <= 1'b0;
      x_addr    <= '0;
      w_addr    <= '0;
      tap_pad   <= 1'b0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
      out_ch    <= '0;
      out_pos   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_start) begin
            state     <= S_RUN;
            tap_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state     <= S_IDLE;
            tap_valid <= 1'b0;
          end else if (hs && final_tap) begin
            state     <= S_DONE;
            tap_valid <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (load) begin
        x_addr    <= x_addr_d;
        w_addr    <= w_addr_d;
        tap_pad   <= pad_d;
        tap_first <= first_d;
        tap_last  <= last_d;
        out_ch    <= co_n;
        out_pos   <= pos_n;
      end
    end
  end

`ifdef CONV1D_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      tap_cnt   <= '0;
    end else if (job_start) begin
      stall_cnt <= '0;
      tap_cnt   <= '0;
    end else if (state == S_RUN) begin
      if (tap_valid && !tap_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (hs && (tap_cnt != '1)) tap_cnt <= tap_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv1d_tap_scheduler.sv
// Self-checking bench: default-geometry scheduler driven through normal, stall, abort
// and reset jobs, plus a strided/dilated instance; taps compared against a model queue.
module tb_conv1d_tap_scheduler;

  localparam int DW = 15;

  logic       clk, rst_n;
  logic       start, abort, tap_ready;
  logic       tap_valid, tap_pad, tap_first, tap_last, busy, done;
  logic [3:0] x_addr, w_addr;
  logic [0:0] out_ch;
  logic [2:0] out_pos;

  logic       g_start, g_abort, g_ready;
  logic       g_tap_valid, g_tap_pad, g_tap_first, g_tap_last, g_busy, g_done;
  logic [3:0] g_x_addr, g_w_addr;
  logic [0:0] g_out_ch;
  logic [0:0] g_out_pos;
`ifdef CONV1D_SCHED_PERF_EN
  logic [31:0] stall_cnt, tap_cnt, g_stall_cnt, g_tap_cnt;
`endif

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] g_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  conv1d_tap_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .tap_valid(tap_valid), .tap_ready(tap_ready),
    .x_addr(x_addr), .w_addr(w_addr), .tap_pad(tap_pad),
    .tap_first(tap_first), .tap_last(tap_last),
    .out_ch(out_ch), .out_pos(out_pos), .busy(busy), .done(done)
`ifdef CONV1D_SCHED_PERF_EN
    , .stall_cnt(stall_cnt), .tap_cnt(tap_cnt)
`endif
  );

  conv1d_tap_scheduler #(
    .IN_LEN(8), .CIN(2), .COUT(2), .K(3), .STRIDE(2), .DIL(2), .PAD(0)
  ) u_geo (
    .clk(clk), .rst_n(rst_n), .start(g_start), .abort(g_abort),
    .tap_valid(g_tap_valid), .tap_ready(g_ready),
    .x_addr(g_x_addr), .w_addr(g_w_addr), .tap_pad(g_tap_pad),
    .tap_first(g_tap_first), .tap_last(g_tap_last),
    .out_ch(g_out_ch), .out_pos(g_out_pos), .busy(g_busy), .done(g_done)
`ifdef CONV1D_SCHED_PERF_EN
    , .stall_cnt(g_stall_cnt), .tap_cnt(g_tap_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack(input bit p, input bit f, input bit l,
                                         input int co, input int pos, input int xa, input int wa);
    logic [DW-1:0] r;
    r = {p, f, l, co[0], pos[2:0], xa[3:0], wa[3:0]};
    return r;
  endfunction

  // Reference model: enumerate taps in co/pos/ci/k order.
  task automatic push_job(input int in_len, input int cin, input int cout, input int kk,
                          input int stride, input int dil, input int pad, input bit geo);
    int ol, ipos, xa, wa;
    bit p;
    ol = (in_len + 2 * pad - dil * (kk - 1) - 1) / stride + 1;
    for (int co = 0; co < cout; co++)
      for (int pos = 0; pos < ol; pos++)
        for (int ci = 0; ci < cin; ci++)
          for (int k = 0; k < kk; k++) begin
            ipos = pos * stride - pad + k * dil;
            p    = (ipos < 0) || (ipos >= in_len);
            xa   = p ? 0 : ci * in_len + ipos;
            wa   = (co * cin + ci) * kk + k;
            if (geo) g_q.push_back(pack(p, ci == 0 && k == 0, ci == cin - 1 && k == kk - 1, co, pos, xa, wa));
            else exp_q.push_back(pack(p, ci == 0 && k == 0, ci == cin - 1 && k == kk - 1, co, pos, xa, wa));
          end
  endtask

  function automatic logic [DW-1:0] cur_desc();
    return pack(tap_pad, tap_first, tap_last, int'(out_ch), int'(out_pos), int'(x_addr), int'(w_addr));
  endfunction

  function automatic logic [17:0] all_outs();
    return {tap_valid, x_addr, w_addr, tap_pad, tap_first, tap_last, out_ch, out_pos, busy, done};
  endfunction

  // Driver + monitor for one default-geometry job.
  task automatic run_job(input int stall_tap, input int stall_len, input int abort_tap,
                         input int rst_tap, output int taps, output int done_rel, output int first_rel);
    int c0, stalled;
    bit ended, was_stall;
    logic [DW-1:0] held, got;
    taps = 0; done_rel = -1; first_rel = -1; stalled = 0; ended = 0; was_stall = 0; held = '0;
    @(negedge clk);
    start = 1'b1; tap_ready = 1'b1; c0 = cyc;
    push_job(8, 2, 2, 3, 1, 1, 1, 1'b0);
    for (int i = 0; i < 300 && !ended; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_rel = cyc - c0;
        ended = 1;
        check("done_valid", tap_valid, 0);
        check("sb_empty", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", done, 0);
      end else if (tap_valid) begin
        if (first_rel < 0) first_rel = cyc - c0;
        got = cur_desc();
        if (was_stall) check("stall_hold", got, held);
        if (taps == abort_tap) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("abort_valid", tap_valid, 0);
          check("abort_busy", busy, 0);
          repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {done, tap_valid}, 0);
          end
          exp_q.delete();
          ended = 1;
        end else if (taps == rst_tap) begin
          rst_n = 1'b0;
          #1;
          check("rst_outs", all_outs(), 0);
          @(negedge clk);
          @(negedge clk);
          rst_n = 1'b1;
          repeat (3) begin
            @(negedge clk);
            check("rst_no_done", {done, tap_valid}, 0);
          end
          exp_q.delete();
          ended = 1;
        end else if (taps == stall_tap && stalled < stall_len) begin
          tap_ready = 1'b0; stalled++; held = got; was_stall = 1;
        end else begin
          tap_ready = 1'b1; was_stall = 0;
          if (exp_q.size() == 0) check("sb_underflow", 1, 0);
          else check("tap", got, exp_q.pop_front());
          // start while running must be ignored
          if (taps == 50) start = 1'b1;
          taps++;
        end
      end
    end
    tap_ready = 1'b1;
    if (!ended) check("job_timeout", 0, 1);
  endtask

  task automatic run_geo();
    int c0, ntap, npad;
    bit ended;
    ntap = 0; npad = 0; ended = 0;
    @(negedge clk);
    g_start = 1'b1; c0 = cyc;
    push_job(8, 2, 2, 3, 2, 2, 0, 1'b1);
    for (int i = 0; i < 80 && !ended; i++) begin
      @(negedge clk);
      g_start = 1'b0;
      if (g_done) begin
        ended = 1;
        check("geo_done_cyc", cyc - c0, 25);
      end else if (g_tap_valid) begin
        if (g_q.size() == 0) check("geo_underflow", 1, 0);
        else check("geo_tap", pack(g_tap_pad, g_tap_first, g_tap_last, int'(g_out_ch),
                                   int'(g_out_pos), int'(g_x_addr), int'(g_w_addr)), g_q.pop_front());
        if (g_out_pos == 1'b1 && g_w_addr == 4'd2) check("geo_x_addr", g_x_addr, 6);
        if (g_tap_pad) npad++;
        ntap++;
      end
    end
    if (!ended) check("geo_timeout", 0, 1);
    check("geo_taps", ntap, 24);
    check("geo_pads", npad, 0);
  endtask

  initial begin
    int taps, done_rel, first_rel;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tap_ready = 1'b1;
    g_start = 1'b0; g_abort = 1'b0; g_ready = 1'b1;
    #3;
    check("reset_outs", all_outs(), 0);
    check("reset_geo", {g_tap_valid, g_busy, g_done, g_x_addr, g_w_addr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // start and abort together in IDLE: stay idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {busy, tap_valid, done}, 0);

    run_job(-1, 0, -1, -1, taps, done_rel, first_rel);
    check("n_first_cyc", first_rel, 1);
    check("n_taps", taps, 96);
    check("n_done_cyc", done_rel, 97);

    run_job(10, 5, -1, -1, taps, done_rel, first_rel);
    check("s_taps", taps, 96);
    check("s_done_cyc", done_rel, 102);
`ifdef CONV1D_SCHED_PERF_EN
    check("perf_stall", stall_cnt, 5);
    check("perf_taps", tap_cnt, 96);
`endif

    run_job(-1, 0, 40, -1, taps, done_rel, first_rel);
    check("a_taps", taps, 40);
    run_job(-1, 0, -1, -1, taps, done_rel, first_rel);
    check("a_restart_taps", taps, 96);
    check("a_restart_done", done_rel, 97);

    run_job(-1, 0, -1, 20, taps, done_rel, first_rel);
    check("r_taps", taps, 20);
    run_job(-1, 0, -1, -1, taps, done_rel, first_rel);
    check("r_restart_first", first_rel, 1);
    check("r_restart_taps", taps, 96);
    check("r_restart_done", done_rel, 97);

    run_geo();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
